// File: rtl/param_onehot_sequencer.sv
// Registered binary-to-one-hot select sequencer with direct, scan and timed-pulse modes.
module param_onehot_sequencer #(
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_mode,
    input  logic [SEL_W-1:0]   cmd_sel_a,
    input  logic [SEL_W-1:0]   cmd_sel_b,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               abort,
    output logic [OUT_W-1:0]   out,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_PULSE  = 2'b10;
    localparam logic [1:0] MODE_CLEAR  = 2'b11;

    // Wrap point of the scan index is the last real output line, not the select range.
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SCAN  = 2'b01,
        ST_PULSE = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [SEL_W-1:0]   end_q, end_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               range_err;
    logic [SEL_W-1:0]   idx_next;

    assign out       = out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cmd_ready = ~busy_q;

    // Out-of-range check on the offered command and the wrapped scan successor index.
    always_comb begin
        range_err = (32'(cmd_sel_a) >= OUT_W) ||
                    ((cmd_mode == MODE_SCAN) && (32'(cmd_sel_b) >= OUT_W));
        idx_next  = (idx_q == LAST_IDX) ? '0 : idx_q + SEL_W'(1);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        end_d   = end_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_mode == MODE_CLEAR) begin
                        out_d = '0;
                    end else if (range_err) begin
                        out_d = '0;
                        err_d = 1'b1;
                    end else begin
                        out_d   = OUT_W'(1) << cmd_sel_a;
                        idx_d   = cmd_sel_a;
                        end_d   = cmd_sel_b;
                        dwell_d = cmd_dwell;
                        cnt_d   = cmd_dwell;
                        if (cmd_mode == MODE_SCAN) begin
                            state_d = ST_SCAN;
                        end else if (cmd_mode == MODE_PULSE) begin
                            state_d = ST_PULSE;
                        end
                    end
                end
            end
            ST_PULSE: begin
                if (abort) begin
                    out_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    out_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    out_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    if (idx_q == end_q) begin
                        out_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_next;
                        cnt_d = dwell_q;
                        out_d = OUT_W'(1) << idx_next;
                    end
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            default: begin
                out_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            end_q   <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            end_q   <= end_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule
